viterbi_block_sequencer: RTL and testbench

//  Sequences the 802.11a receiver Viterbi decoder (Data/Clk/EN/Reset/Out) one 96-coded-bit block at a time.

---
 rtl/viterbi_block_sequencer.sv | 141 ++++++++++++++
 tb/tb_viterbi_block_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_block_sequencer.sv
// Viterbi block sequencer: buffers 96-bit coded blocks and bursts them into
// the 802.11a Viterbi decoder, then passes the 48 decoded bits straight out.
// The fill buffer loads the next block while the current one is decoded.
module viterbi_block_sequencer #(
  parameter int IN_BITS     = 96,
  parameter int CALC_CYCLES = 96,
  parameter int OUT_BITS    = 48,
  parameter int NBLK_W      = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [NBLK_W-1:0] n_blocks,
  input  logic              abort,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dec_en,
  output logic              dec_data,
  input  logic              dec_out,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int PH_MAX0 = (IN_BITS > CALC_CYCLES) ? IN_BITS : CALC_CYCLES;
  localparam int PH_MAX  = (PH_MAX0 > OUT_BITS) ? PH_MAX0 : OUT_BITS;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int FC_W    = $clog2(IN_BITS + 1);

  localparam logic [PH_W-1:0] LD_LAST = PH_W'(IN_BITS - 1);
  localparam logic [PH_W-1:0] CA_LAST = PH_W'(CALC_CYCLES - 1);
  localparam logic [PH_W-1:0] DR_LAST = PH_W'(OUT_BITS - 1);
  localparam logic [FC_W-1:0] FC_FULL = FC_W'(IN_BITS);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(IN_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_CALC, S_DRAIN, S_GAP} state_t;

  state_t             state, state_nxt;
  logic [PH_W-1:0]    ph_cnt;
  logic [FC_W-1:0]    fill_cnt;
  logic [IN_BITS-1:0] fbuf, sbuf;
  logic [NBLK_W-1:0]  blk_acc, blk_done, n_blocks_q;
  logic               zero_done_q;

  logic fill_full, more, start_ok, accept, xfer, gap_done, dr_end;

  assign fill_full = (fill_cnt == FC_FULL);
  assign more      = (blk_done < n_blocks_q);
  assign start_ok  = (state == S_IDLE) && frame_start && !abort;
  assign busy      = (state != S_IDLE);
  assign in_ready  = busy && !fill_full && (blk_acc < n_blocks_q) && !abort;
  assign accept    = in_valid && in_ready;
  assign dr_end    = (state == S_DRAIN) && (ph_cnt == DR_LAST);

  // next state, block transfer strobe and decoder/output drive
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    gap_done  = 1'b0;
    dec_en    = 1'b0;
    dec_data  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_IDLE:  if (frame_start && n_blocks != '0) state_nxt = S_WAIT;
      S_WAIT:  if (fill_full) begin xfer = 1'b1; state_nxt = S_LOAD; end
      S_LOAD: begin
        dec_en   = 1'b1;
        dec_data = sbuf[ph_cnt];
        if (ph_cnt == LD_LAST) state_nxt = S_CALC;
      end
      S_CALC: begin
        dec_en = 1'b1;
        if (ph_cnt == CA_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        dec_en    = 1'b1;
        out_valid = 1'b1;
        if (dr_end) begin
          state_nxt = S_GAP;
          out_last  = ((blk_done + NBLK_W'(1)) == n_blocks_q);
        end
      end
      S_GAP: begin
        // a block already waiting skips WAIT so the decoder reset is one cycle
        if (more) begin
          if (fill_full) begin xfer = 1'b1; state_nxt = S_LOAD; end
          else state_nxt = S_WAIT;
        end else begin
          gap_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      xfer      = 1'b0;
      gap_done  = 1'b0;
    end
  end

  assign out_bit    = out_valid & dec_out;
  assign frame_done = gap_done | zero_done_q;

  // state, phase counter, frame bookkeeping and double buffer
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      fill_cnt    <= '0;
      fbuf        <= '0;
      sbuf        <= '0;
      blk_acc     <= '0;
      blk_done    <= '0;
      n_blocks_q  <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      ph_cnt      <= (state_nxt != state) ? '0 : ph_cnt + PH_W'(1);
      zero_done_q <= start_ok && (n_blocks == '0);
      if (start_ok) begin
        n_blocks_q <= n_blocks;
        blk_acc    <= '0;
        blk_done   <= '0;
      end
      if (dr_end && !abort) blk_done <= blk_done + NBLK_W'(1);
      if (abort || xfer) fill_cnt <= '0;
      else if (accept) begin
        fbuf[fill_cnt] <= in_bit;
        fill_cnt       <= fill_cnt + FC_W'(1);
      end
      if (accept && fill_cnt == FC_LAST) blk_acc <= blk_acc + NBLK_W'(1);
      if (xfer) sbuf <= fbuf;
    end
  end

endmodule

// File: tb/tb_viterbi_block_sequencer.sv
// Bench for viterbi_block_sequencer: random input and decoder-output streams,
// a block-level reference (accepted bits grouped into 96-bit blocks, fixed
// per-block timeline) checked against what the decoder port and output see.
module tb_viterbi_block_sequencer;
  localparam int IN_BITS = 96, CALC_CYCLES = 96, OUT_BITS = 48, NBLK_W = 8;
  localparam int RUN_LEN = IN_BITS + CALC_CYCLES + OUT_BITS;
  localparam int PERIOD  = RUN_LEN + 1;

  logic Clk = 0, Reset_n = 0, frame_start = 0, abort = 0;
  logic in_bit = 0, in_valid = 0, dec_out = 0;
  logic [NBLK_W-1:0] n_blocks = '0;
  logic in_ready, dec_en, dec_data, out_bit, out_valid, out_last, busy, frame_done;

  viterbi_block_sequencer #(.IN_BITS(IN_BITS), .CALC_CYCLES(CALC_CYCLES),
    .OUT_BITS(OUT_BITS), .NBLK_W(NBLK_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .n_blocks(n_blocks),
    .abort(abort), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .dec_en(dec_en), .dec_data(dec_data), .dec_out(dec_out), .out_bit(out_bit),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .frame_done(frame_done));

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stimulus driver: in_valid mode 0 off, 1 always, 2 one-in-three, 3 random
  int vmode = 0, dcyc = 0, acc_total = 0;
  bit pat = 0;
  logic [7:0] a5 = 8'hA5;
  always @(posedge Clk) begin
    #1;
    dcyc++;
    case (vmode)
      0: in_valid = 1'b0;
      1: in_valid = 1'b1;
      2: in_valid = (dcyc % 3 == 0);
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    in_bit  = pat ? a5[acc_total % 8] : 1'($urandom);
    dec_out = 1'($urandom);
  end

  // reference: accepted bits form blocks; each block gives a 240-cycle
  // dec_en burst: 96 data bits, 96 zero bits, 48 output bits, then a gap
  bit acc_q[$];
  logic [IN_BITS-1:0] blk_q[$];
  logic [IN_BITS-1:0] cap, pk;
  int starts[$];
  int cyc = 0, run = 0, blk_seen = 0, cur_nb = 0, fd_cnt = 0, n_ov = 0, n_last = 0;
  int calc_err = 0, ov_err = 0, ob_err = 0, last_err = 0;

  always @(negedge Clk) begin
    cyc++;
    if (!Reset_n) begin
      acc_q.delete(); blk_q.delete(); run = 0;
    end else begin
      if (frame_done) fd_cnt++;
      if (out_valid) n_ov++;
      if (out_last) n_last++;
      if (out_valid && out_bit !== dec_out) ob_err++;
      if (in_valid && in_ready) begin
        acc_q.push_back(in_bit);
        acc_total++;
        if (acc_q.size() == IN_BITS) begin
          for (int k = 0; k < IN_BITS; k++) pk[k] = acc_q[k];
          blk_q.push_back(pk);
          acc_q.delete();
        end
      end
      if (dec_en) begin
        if (run == 0) starts.push_back(cyc);
        if (run < IN_BITS) cap[run] = dec_data;
        else if (run < IN_BITS + CALC_CYCLES && dec_data !== 1'b0) calc_err++;
        if (out_valid !== (run >= IN_BITS + CALC_CYCLES)) ov_err++;
        if (out_last !== (run == RUN_LEN - 1 && blk_seen + 1 == cur_nb)) last_err++;
        run++;
      end else begin
        if (out_valid || out_last) ov_err++;
        if (run > 0) begin
          chk("en_len", run, RUN_LEN);
          if (blk_q.size() == 0) chk("blk_avail", 0, 1);
          else chk("load_data", cap, blk_q.pop_front());
          blk_seen++;
          chk("gap_fdone", frame_done, blk_seen == cur_nb);
          run = 0;
        end
      end
      if (abort) begin
        chk("abort_rdy", in_ready, 0);
        acc_q.delete(); blk_q.delete(); run = 0;
      end
    end
  end

  task automatic start_frame(input int nb, input int mode, input bit p);
    cur_nb = nb; blk_seen = 0; starts.delete(); acc_total = 0;
    calc_err = 0; ov_err = 0; ob_err = 0; last_err = 0;
    vmode = mode; pat = p;
    @(posedge Clk); #2; frame_start = 1; n_blocks = NBLK_W'(nb);
    @(posedge Clk); #2; frame_start = 0; n_blocks = NBLK_W'($urandom);
  endtask

  task automatic run_frame(input int nb, input int mode, input bit p, input bit poke);
    int fd0, ov0, l0;
    fd0 = fd_cnt; ov0 = n_ov; l0 = n_last;
    start_frame(nb, mode, p);
    for (int i = 0; i < nb * 400 + 600 && fd_cnt == fd0; i++) begin
      @(posedge Clk); #2;
      if (poke && i == 150) begin frame_start = 1; n_blocks = 8'd5; end
      else frame_start = 0;
    end
    frame_start = 0; vmode = 0;
    repeat (3) @(negedge Clk);
    chk("fd_count", fd_cnt - fd0, 1);
    chk("blocks", blk_seen, nb);
    chk("busy_end", busy, 0);
    chk("ov_count", n_ov - ov0, OUT_BITS * nb);
    chk("last_count", n_last - l0, 1);
    chk("calc_zero", calc_err, 0);
    chk("ov_window", ov_err, 0);
    chk("out_pass", ob_err, 0);
    chk("out_last", last_err, 0);
    chk("blkq_empty", blk_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_outs", {in_ready, dec_en, dec_data, out_bit, out_valid, out_last, busy, frame_done}, 8'h00);
    @(posedge Clk); #2; Reset_n = 1;

    // single block, continuous input
    run_frame(1, 1, 0, 0);
    // three blocks back to back
    run_frame(3, 1, 0, 0);
    if (starts.size() == 3) begin
      chk("period_1", starts[1] - starts[0], PERIOD);
      chk("period_2", starts[2] - starts[1], PERIOD);
    end else chk("starts", starts.size(), 3);
    // A5 pattern into the decoder, bit 0 first
    run_frame(1, 1, 1, 0);
    chk("a5_load", cap, {12{8'hA5}});
    // sparse input keeps WAIT until the block is full
    run_frame(2, 2, 0, 0);
    // frame_start while busy is ignored
    run_frame(1, 1, 0, 1);

    // abort in DRAIN bit 20 of block 2 of 4
    begin
      int fd0;
      fd0 = fd_cnt;
      start_frame(4, 1, 0);
      for (int i = 0; i < 2000 && !(blk_seen == 1 && run == IN_BITS + CALC_CYCLES + 20); i++) begin
        @(posedge Clk); #2;
      end
      chk("abort_reach", (blk_seen == 1 && run == IN_BITS + CALC_CYCLES + 20), 1);
      abort = 1;
      @(posedge Clk); #2; abort = 0;
      @(negedge Clk);
      chk("abort_state", {dec_en, busy, out_valid, in_ready}, 4'h0);
      repeat (300) @(negedge Clk);
      chk("abort_nofd", fd_cnt - fd0, 0);
      // abort wins over a simultaneous frame_start
      @(posedge Clk); #2; frame_start = 1; abort = 1; n_blocks = 8'd2;
      @(posedge Clk); #2; frame_start = 0; abort = 0;
      @(negedge Clk);
      chk("abort_start", {busy, frame_done}, 2'b00);
      vmode = 0;
    end
    run_frame(1, 1, 0, 0);

    // zero-block frame
    @(posedge Clk); #2; frame_start = 1; n_blocks = 8'd0;
    @(posedge Clk); #2; frame_start = 0;
    @(negedge Clk);
    chk("zero_fd", {frame_done, busy}, 2'b10);
    @(negedge Clk);
    chk("zero_fd_end", {frame_done, busy}, 2'b00);

    // reset in the middle of CALC
    start_frame(2, 1, 0);
    for (int i = 0; i < 2000 && run != IN_BITS + 4; i++) begin
      @(posedge Clk); #2;
    end
    Reset_n = 0;
    @(negedge Clk);
    chk("rst_mid", {dec_en, busy, in_ready, out_valid}, 4'h0);
    vmode = 0;
    @(posedge Clk); #2; Reset_n = 1;

    // random frames with random input gaps
    for (int f = 0; f < 3; f++) run_frame($urandom_range(1, 3), 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
